repeated_sub_divider: RTL

REPEATED_SUB_DIVIDER -- requirements
Module: repeated_sub_divider

---
 rtl/div_pkg.sv | 5 +
 rtl/div_datapath.sv | 66 ++++++
 rtl/repeated_sub_divider.sv | 54 +++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the repeated-subtraction divider
package div_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;
    localparam int DIV_W_DEFAULT = 5;
endpackage

// File: rtl/div_datapath.sv
// rtl/div_datapath.sv - remainder/divisor/quotient registers with subtract and compare (DIV_EARLY_EQ_EN adds early finish on rem==div)
module div_datapath
    import div_pkg::*;
#(
    parameter int N = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         last_step,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    logic [N-1:0] rem_q, rem_d;
    logic [N-1:0] div_q, div_d;
    logic [N-1:0] quo_q, quo_d;
    logic         dbz_q, dbz_d;
    logic         ge;

    assign ge = (rem_q >= div_q);

`ifdef DIV_EARLY_EQ_EN
    // An exact match subtracts this cycle and is necessarily the final step.
    assign last_step = !ge || (rem_q == div_q);
`else
    assign last_step = !ge;
`endif

    always_comb begin
        rem_d = rem_q;
        div_d = div_q;
        quo_d = quo_q;
        dbz_d = dbz_q;
        if (load) begin
            div_d = divisor;
            rem_d = dividend;
            dbz_d = (divisor == '0);
            quo_d = (divisor == '0) ? '1 : '0;
        end else if (step && ge) begin
            rem_d = rem_q - div_q;
            quo_d = quo_q + N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            quo_q <= quo_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: rtl/repeated_sub_divider.sv
// rtl/repeated_sub_divider.sv - unsigned divider controller; DIV_EARLY_EQ_EN selects early finish in div_datapath
module repeated_sub_divider
    import div_pkg::*;
#(
    parameter int N = DIV_W_DEFAULT
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         DivByZero
);
    state_t state_q, state_d;
    logic   accept;
    logic   last_step;

    assign accept = Start && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (Divisor == '0) ? S_DONE : S_SUB;
            S_SUB:  if (last_step) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign Busy = (state_q == S_SUB);
    assign Done = (state_q == S_DONE);

    div_datapath #(.N(N)) u_datapath (
        .clk         (Clk),
        .resetn      (Reset),
        .load        (accept),
        .step        (state_q == S_SUB),
        .dividend    (Dividend),
        .divisor     (Divisor),
        .last_step   (last_step),
        .quotient    (Quotient),
        .remainder   (Remainder),
        .div_by_zero (DivByZero)
    );
endmodule
